uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched_pkg.sv | 15 +
 rtl/uart_tx_sched_if.sv | 31 +++
 rtl/uart_rr_picker.sv | 29 ++
 rtl/uart_tx_sched.sv | 116 +++++++++++
 tb/tb_uart_tx_sched.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared UART scheduler package: default sizing and the scheduler state encoding.
package uart_tx_sched_pkg;

  localparam int NREQ_DEF         = 4;
  localparam int DWIDTH_DEF       = 8;
  localparam int BUSY_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } sched_state_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side and UART-TX-side handshake bundle of the TX scheduler.
interface uart_tx_sched_if
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DWIDTH = DWIDTH_DEF
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_par_en;
  logic [NREQ-1:0]        req_par_typ;
  logic [NREQ-1:0]        req_ready;
  logic [DWIDTH-1:0]      tx_p_data;
  logic                   tx_data_valid;
  logic                   tx_par_en;
  logic                   tx_par_typ;
  logic                   tx_busy;

  // master: the scheduler; slave: requesters plus the UART transmitter
  modport master (
    input  req_valid, req_data, req_par_en, req_par_typ, tx_busy,
    output req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
  );

  modport slave (
    output req_valid, req_data, req_par_en, req_par_typ, tx_busy,
    input  req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
  );

endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module uart_rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    any_valid,
  output logic [$clog2(NREQ)-1:0] sel
);

  localparam int IW = $clog2(NREQ);

  int idx;

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    any_valid = 1'b0;
    sel       = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        sel       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers.
// Optional WAIT_BUSY abort is enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ         = NREQ_DEF,
  parameter int DWIDTH       = DWIDTH_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  uart_tx_sched_if.master         bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    sched_busy,
  output logic                    timeout_err
);

  localparam int IW = $clog2(NREQ);

  sched_state_e    state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   sel;
  logic            any_valid;
  logic            accept;
  logic            done;
  logic            abort;
  logic [NREQ-1:0] ready_c;

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] id);
    return (id == IW'(NREQ - 1)) ? '0 : id + IW'(1);
  endfunction

  uart_rr_picker #(.NREQ(NREQ)) u_picker (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .any_valid (any_valid),
    .sel       (sel)
  );

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  // Abort on the BUSY_TIMEOUT-th idle WAIT_BUSY cycle.
  assign abort = (state == WAIT_BUSY) && !bus.tx_busy &&
                 (to_cnt == CW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST || state == ISSUE)
      to_cnt <= '0;
    else if (state == WAIT_BUSY && !bus.tx_busy)
      to_cnt <= to_cnt + CW'(1);
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ready_c   = '0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.tx_busy && any_valid) begin
          ready_c[sel] = 1'b1;
          accept       = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)
          state_nxt = WAIT_DONE;
        else if (abort)
          state_nxt = IDLE;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready     = RST ? '0 : ready_c;
  assign bus.tx_data_valid = (state == ISSUE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant_id       <= '0;
      bus.tx_p_data  <= '0;
      bus.tx_par_en  <= 1'b0;
      bus.tx_par_typ <= 1'b0;
      sched_busy     <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      sched_busy  <= (state_nxt != IDLE);
      timeout_err <= abort;
      if (accept) begin
        grant_id       <= sel;
        bus.tx_p_data  <= bus.req_data[sel*DWIDTH +: DWIDTH];
        bus.tx_par_en  <= bus.req_par_en[sel];
        bus.tx_par_typ <= bus.req_par_typ[sel];
      end
      if (done || abort)
        rr_ptr <= ptr_after(grant_id);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed-vector bench for uart_tx_sched; acts as both the requesters and the UART TX.
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] grant_id;
  logic       sched_busy;
  logic       timeout_err;
  int         n_vec = 0;
  int         n_err = 0;
  int         pulses;

  uart_tx_sched_if #(.NREQ(4), .DWIDTH(8)) bus ();

  uart_tx_sched #(.NREQ(4), .DWIDTH(8), .BUSY_TIMEOUT(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called in the ISSUE cycle; finishes one frame with tx_busy high for busy_cycles.
  task automatic serve(input int busy_cycles, output int p);
    p = int'(bus.tx_data_valid);
    tick();
    p += int'(bus.tx_data_valid);
    bus.tx_busy = 1'b1;
    tick();
    p += int'(bus.tx_data_valid);
    repeat (busy_cycles - 1) begin
      tick();
      p += int'(bus.tx_data_valid);
    end
    bus.tx_busy = 1'b0;
    tick();
    p += int'(bus.tx_data_valid);
  endtask

  task automatic do_reset();
    RST             = 1'b1;
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.req_par_en  = '0;
    bus.req_par_typ = '0;
    bus.tx_busy     = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_dv"},    32'(bus.tx_data_valid), 32'h0);
    chk({tag, "_data"},  32'(bus.tx_p_data),     32'h0);
    chk({tag, "_paren"}, 32'(bus.tx_par_en),     32'h0);
    chk({tag, "_partyp"},32'(bus.tx_par_typ),    32'h0);
    chk({tag, "_gid"},   32'(grant_id),          32'h0);
    chk({tag, "_busy"},  32'(sched_busy),        32'h0);
    chk({tag, "_toerr"}, 32'(timeout_err),       32'h0);
  endtask

  initial begin
    // Reset state, with requests pending to prove req_ready is forced low
    do_reset();
    RST = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk_reset_outs("rst");
    RST = 1'b0;
    bus.req_valid = '0;
    tick();

    // Single request from requester 2
    bus.req_data    = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.req_par_en  = 4'b0100;
    bus.req_par_typ = 4'b0100;
    bus.req_valid   = 4'b0100;
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    #1;
    chk("t1_ready_off", 32'(bus.req_ready),     32'h0);
    chk("t1_dv",        32'(bus.tx_data_valid), 32'h1);
    chk("t1_data",      32'(bus.tx_p_data),     32'hA5);
    chk("t1_paren",     32'(bus.tx_par_en),     32'h1);
    chk("t1_partyp",    32'(bus.tx_par_typ),    32'h1);
    chk("t1_gid",       32'(grant_id),          32'h2);
    chk("t1_busy",      32'(sched_busy),        32'h1);
    serve(3, pulses);
    chk("t1_pulses",    32'(pulses),            32'h1);
    chk("t1_idle",      32'(sched_busy),        32'h0);
    chk("t1_hold_data", 32'(bus.tx_p_data),     32'hA5);

    // All four valid continuously, 10 busy cycles per frame
    do_reset();
    bus.req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_par_en  = 4'b1010;
    bus.req_par_typ = 4'b0110;
    bus.req_valid   = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      int e;
      e = f % 4;
      #1;
      chk($sformatf("rr%0d_ready", f), 32'(bus.req_ready), 32'(1 << e));
      tick();
      chk($sformatf("rr%0d_gid", f),  32'(grant_id),       32'(e));
      chk($sformatf("rr%0d_data", f), 32'(bus.tx_p_data), 32'(8'h10 + e));
      chk($sformatf("rr%0d_par", f),
          32'({bus.tx_par_en, bus.tx_par_typ}),
          32'({(e == 1 || e == 3), (e == 1 || e == 2)}));
      serve(10, pulses);
      chk($sformatf("rr%0d_pulses", f), 32'(pulses), 32'h1);
    end

    // rr_ptr=1: serve requester 1, then req0/req3 contend with rr_ptr=2
    bus.req_valid = 4'b0010;
    #1;
    chk("t3_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    serve(2, pulses);
    bus.req_valid = 4'b1001;
    #1;
    chk("t3_ready3", 32'(bus.req_ready), 32'h8);
    tick();
    chk("t3_gid3", 32'(grant_id), 32'h3);
    serve(2, pulses);
    #1;
    chk("t3_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("t3_gid0", 32'(grant_id), 32'h0);
    serve(2, pulses);

    // tx_busy held high in IDLE blocks the grant
    bus.tx_busy   = 1'b1;
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t4_block%0d", i), 32'(bus.req_ready), 32'h0);
      tick();
    end
    chk("t4_busy_idle", 32'(sched_busy), 32'h0);
    bus.tx_busy = 1'b0;
    #1;
    chk("t4_release", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    serve(2, pulses);

    // Transmitter never raises busy
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    chk("t5_dv", 32'(bus.tx_data_valid), 32'h1);
    tick();
`ifdef UART_SCHED_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) begin
        chk($sformatf("t5_toerr%0d", i), 32'(timeout_err), 32'h0);
        chk($sformatf("t5_busy%0d", i),  32'(sched_busy),  32'h1);
      end else begin
        chk("t5_toerr_pulse", 32'(timeout_err), 32'h1);
        chk("t5_busy_drop",   32'(sched_busy),  32'h0);
      end
    end
    tick();
    chk("t5_toerr_end", 32'(timeout_err), 32'h0);
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("t5_busy%0d", i),  32'(sched_busy),  32'h1);
      chk($sformatf("t5_toerr%0d", i), 32'(timeout_err), 32'h0);
    end
    bus.tx_busy = 1'b1;
    tick();
    bus.tx_busy = 1'b0;
    tick();
    chk("t5_done", 32'(sched_busy), 32'h0);
`endif

    // Reset in WAIT_DONE (rr_ptr is 2 beforehand)
    bus.req_valid = 4'b0100;
    #1;
    chk("t6_ready2", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    tick();
    bus.tx_busy = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("t6_rst_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk_reset_outs("t6");
    RST         = 1'b0;
    bus.tx_busy = 1'b0;
    bus.req_valid = 4'b1010;
    #1;
    chk("t6_ptr0", 32'(bus.req_ready), 32'h2);
    bus.req_valid = 4'b1000;
    #1;
    chk("t6_ready3", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = '0;
    chk("t6_gid3", 32'(grant_id),          32'h3);
    chk("t6_dv",   32'(bus.tx_data_valid), 32'h1);
    serve(2, pulses);
    chk("t6_pulses", 32'(pulses), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
